// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard sequencer state codes, register
// constants and the load-use detection helper.
package pipe_pkg;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DWAIT = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    // True when the ID instruction reads the register a load in EX is about to write.
    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        return ex_mem_read && (ex_rd != REG_ZERO) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-memory waits with a
// watchdog, taken-branch redirects, load-use bubbles and fetch misses.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

    logic [1:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        dmem_wait;
    logic        hazard;
    logic        active;

    assign dmem_wait = dmem_req && !dmem_ready;
    assign hazard    = load_use(ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
    assign active    = rst && (state_q != ERR);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        if (!active) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (dmem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // The watchdog trips on the MAX_WAIT-th consecutive wait cycle, i.e. when the
    // count would advance to MAX_WAIT; dropping the wait in DWAIT always releases.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (dmem_wait) begin
                    state_d    = DWAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            DWAIT: begin
                if (!dmem_wait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if ((wait_cnt_q + 16'd1) == WAIT_LIMIT) begin
                    state_d       = ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!rst),
        .inc   (active && !pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (!rst),
        .inc   (active && !dmem_wait && ex_branch_taken),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle model of the control rules is compared
// every cycle, with literal expectations at key points of each scenario.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 4;
    localparam int          SAT      = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic             imem_ready, dmem_req, dmem_ready;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: halted flag, consecutive wait cycles, event counts.
    bit m_err   = 1'b0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_flush     (memwb_flush),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected controls as {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}.
    function automatic logic [6:0] model_ctrl();
        bit lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!rst || m_err)              return 7'b000_0000;
        if (dmem_req && !dmem_ready)    return 7'b000_0001;
        if (ex_branch_taken)            return 7'b111_1110;
        if (lu)                         return 7'b000_1110;
        if (!imem_ready)                return 7'b011_1010;
        return 7'b110_1010;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [6:0] c;
        c = model_ctrl();
        if (!rst) begin
            m_err   <= 1'b0;
            m_waits <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else if (!m_err) begin
            if (!c[6] && m_stall < SAT) m_stall <= m_stall + 1;
            if (dmem_req && !dmem_ready) begin
                m_waits <= m_waits + 1;
                if (m_waits + 1 >= MAX_WAIT) m_err <= 1'b1;
            end else begin
                m_waits <= 0;
                if (ex_branch_taken && m_flush < SAT) m_flush <= m_flush + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl", int'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}),
                int'(model_ctrl()));
            chk("mem_timeout", int'(mem_timeout), int'(m_err));
            chk("stall_cnt", int'(stall_cnt), m_stall);
            chk("flush_cnt", int'(flush_cnt), m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        chk_en = 1'b1;
        #1;
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        tick();
        rst = 1'b1;

        // Load-use on rs2, then on rs1, then non-hazards
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        chk("lu_pc_en", int'(pc_en), 0);
        chk("lu_ifid_en", int'(ifid_en), 0);
        chk("lu_idex_flush", int'(idex_flush), 1);
        tick();
        chk("lu_stall1", int'(stall_cnt), 1);
        idle();
        #1;
        chk("lu_release", int'(pc_en), 1);
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        tick();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #1;
        chk("lu_rd0", int'(pc_en), 1);
        tick();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b0;
        tick();
        chk("lu_stall2", int'(stall_cnt), 2);

        // Branch while the load-use condition holds
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("br_pc_en", int'(pc_en), 1);
        chk("br_ifid_flush", int'(ifid_flush), 1);
        chk("br_idex_flush", int'(idex_flush), 1);
        tick();
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 2);

        // Data-memory wait with a pending branch
        idle();
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("dw_memwb_flush", int'(memwb_flush), 1);
        chk("dw_exmem_en", int'(exmem_en), 0);
        repeat (3) tick();
        dmem_ready = 1'b1;
        #1;
        chk("dw_rel_pc_en", int'(pc_en), 1);
        chk("dw_rel_ifid_flush", int'(ifid_flush), 1);
        chk("dw_rel_memwb", int'(memwb_flush), 0);
        tick();
        chk("dw_flush_cnt", int'(flush_cnt), 2);
        chk("dw_stall_cnt", int'(stall_cnt), 5);
        idle();
        tick();

        // Imem miss
        do_reset();
        imem_ready = 1'b0;
        #1;
        chk("im_pc_en", int'(pc_en), 0);
        chk("im_ifid_flush", int'(ifid_flush), 1);
        chk("im_idex_en", int'(idex_en), 1);
        chk("im_exmem_en", int'(exmem_en), 1);
        repeat (2) tick();
        chk("im_stall_cnt", int'(stall_cnt), 2);
        idle();

        // Watchdog
        dmem_req = 1'b1;
        repeat (3) tick();
        chk("wd_not_yet", int'(mem_timeout), 0);
        tick();
        chk("wd_timeout", int'(mem_timeout), 1);
        chk("wd_stall_cnt", int'(stall_cnt), 6);
        dmem_ready = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("wd_err_pc_en", int'(pc_en), 0);
        chk("wd_err_flush", int'(ifid_flush), 0);
        repeat (2) tick();
        chk("wd_err_sticky", int'(mem_timeout), 1);
        chk("wd_err_stall", int'(stall_cnt), 6);
        chk("wd_err_flushcnt", int'(flush_cnt), 0);
        do_reset();
        idle();
        #1;
        chk("wd_clr_timeout", int'(mem_timeout), 0);
        chk("wd_clr_stall", int'(stall_cnt), 0);
        chk("wd_clr_pc_en", int'(pc_en), 1);
        tick();

        // Saturation
        imem_ready = 1'b0;
        repeat (20) tick();
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        idle();
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
